// File: rtl/prog_loader_if.sv
// Loader bus bundle: byte stream in, instruction-memory write port out,
// core reset and status flags out.
//   master : the loader (consumes the stream, drives memory/core/status)
//   slave  : the surrounding system (byte source, instruction memory, core)
interface prog_loader_if #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  PROG_LOADER_Start_in;
  logic                  PROG_LOADER_Byte_Valid_in;
  logic [7:0]            PROG_LOADER_Byte_InBUS;
  logic                  PROG_LOADER_Byte_Ready_out;
  logic                  PROG_LOADER_Mem_We_out;
  logic [ADDR_WIDTH-1:0] PROG_LOADER_Mem_Addr_OutBUS;
  logic [DATAWIDTH-1:0]  PROG_LOADER_Mem_Data_OutBUS;
  logic                  PROG_LOADER_Core_Reset_out;
  logic                  PROG_LOADER_Done_out;
  logic                  PROG_LOADER_Error_out;

  modport master (
    input  PROG_LOADER_Start_in, PROG_LOADER_Byte_Valid_in, PROG_LOADER_Byte_InBUS,
    output PROG_LOADER_Byte_Ready_out, PROG_LOADER_Mem_We_out,
           PROG_LOADER_Mem_Addr_OutBUS, PROG_LOADER_Mem_Data_OutBUS,
           PROG_LOADER_Core_Reset_out, PROG_LOADER_Done_out, PROG_LOADER_Error_out
  );

  modport slave (
    output PROG_LOADER_Start_in, PROG_LOADER_Byte_Valid_in, PROG_LOADER_Byte_InBUS,
    input  PROG_LOADER_Byte_Ready_out, PROG_LOADER_Mem_We_out,
           PROG_LOADER_Mem_Addr_OutBUS, PROG_LOADER_Mem_Data_OutBUS,
           PROG_LOADER_Core_Reset_out, PROG_LOADER_Done_out, PROG_LOADER_Error_out
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a little-endian byte stream (word count, words,
// XOR checksum), writes the words into instruction memory and releases the
// core from reset only after the checksum matches.
// Ports:
//   PROG_LOADER_Clk_in    - system clock, rising edge
//   PROG_LOADER_Reset_in  - asynchronous active-low reset
//   bus (master)          - stream input, memory write port, core reset, Done/Error
module prog_loader #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic           PROG_LOADER_Clk_in,
  input  logic           PROG_LOADER_Reset_in,
  prog_loader_if.master  bus
);
  localparam int unsigned DW    = DATAWIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]  word_idx_q, word_idx_d;
  logic [7:0]     xor_q, xor_d;
  logic [31:0]    count_q, count_d;
  logic [23:0]    asm_q, asm_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           ready_q, ready_d;
  logic           core_rst_q, core_rst_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           accept;
  logic [7:0]     in_byte;
  logic [31:0]    count_full;

  assign in_byte    = bus.PROG_LOADER_Byte_InBUS;
  assign accept     = bus.PROG_LOADER_Byte_Valid_in & ready_q;
  // Count with the current byte placed on top; complete on the 4th header byte.
  assign count_full = {in_byte, count_q[31:8]};

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    xor_d      = xor_q;
    count_d    = count_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          xor_d      = xor_q ^ in_byte;
          count_d    = count_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (count_full == 32'd0 || count_full > 32'(DEPTH)) state_d = S_ERR;
            else                                                state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ in_byte;
          asm_d      = {in_byte, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            data_d     = DW'({in_byte, asm_q});
            word_idx_d = word_idx_q + AW'(1);
            if (32'(word_idx_q) == count_q - 32'd1) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_byte == xor_q) state_d = S_RUN;
          else                  state_d = S_ERR;
        end
      end
      S_RUN, S_ERR: begin
        if (bus.PROG_LOADER_Start_in) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          xor_d      = 8'd0;
          count_d    = 32'd0;
          asm_d      = 24'd0;
        end
      end
      default: state_d = S_HDR;
    endcase

    // Status flags follow the state being entered so they appear one cycle
    // after the deciding byte or Start.
    ready_d    = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
    core_rst_d = (state_d == S_RUN);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERR);
  end

  // State and output registers
  always_ff @(posedge PROG_LOADER_Clk_in or negedge PROG_LOADER_Reset_in) begin
    if (!PROG_LOADER_Reset_in) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      xor_q      <= 8'd0;
      count_q    <= 32'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b1;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      xor_q      <= xor_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.PROG_LOADER_Byte_Ready_out  = ready_q;
  assign bus.PROG_LOADER_Mem_We_out      = we_q;
  assign bus.PROG_LOADER_Mem_Addr_OutBUS = addr_q;
  assign bus.PROG_LOADER_Mem_Data_OutBUS = data_q;
  assign bus.PROG_LOADER_Core_Reset_out  = core_rst_q;
  assign bus.PROG_LOADER_Done_out        = done_q;
  assign bus.PROG_LOADER_Error_out       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte-stream stimulus against a queue-based model of
// the image format, compared every cycle, plus literal expectations.
module tb_prog_loader;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  typedef byte unsigned bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef enum {P_LOAD, P_RUN, P_ERR} phase_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.DATAWIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  prog_loader #(.DATAWIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .PROG_LOADER_Clk_in   (clk),
    .PROG_LOADER_Reset_in (rst_n),
    .bus                  (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory stand-in and write-pulse counter
  logic [31:0] tb_mem [0:(1<<AW)-1];
  int we_cnt = 0;
  always @(posedge clk)
    if (bus.PROG_LOADER_Mem_We_out) tb_mem[bus.PROG_LOADER_Mem_Addr_OutBUS] <= bus.PROG_LOADER_Mem_Data_OutBUS;
  always @(negedge clk)
    if (bus.PROG_LOADER_Mem_We_out === 1'b1) we_cnt++;

  // Reference model: keeps every accepted byte and derives the expected
  // outputs for the following cycle from the image format.
  phase_t        ph     = P_LOAD;
  byte unsigned  acc[$];
  logic [31:0]   m_n    = '0;
  logic          e_we   = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_data = '0;
  int            m_len;
  byte unsigned  m_x;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc.delete(); ph = P_LOAD; e_we = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      e_we = 1'b0;
      if (ph != P_LOAD) begin
        if (bus.PROG_LOADER_Start_in) begin acc.delete(); ph = P_LOAD; end
      end else if (bus.PROG_LOADER_Byte_Valid_in) begin
        acc.push_back(bus.PROG_LOADER_Byte_InBUS);
        m_len = acc.size();
        if (m_len == 4) begin
          m_n = {acc[3], acc[2], acc[1], acc[0]};
          if (m_n == 0 || m_n > 32'(1 << AW)) ph = P_ERR;
        end else if (m_len > 4 && m_len <= 4 + 4 * int'(m_n)) begin
          if ((m_len - 4) % 4 == 0) begin
            e_we   = 1'b1;
            e_addr = AW'((m_len - 8) / 4);
            e_data = {acc[m_len-1], acc[m_len-2], acc[m_len-3], acc[m_len-4]};
          end
        end else if (m_len == 5 + 4 * int'(m_n)) begin
          m_x = 0;
          for (int i = 0; i < m_len - 1; i++) m_x ^= acc[i];
          ph = (m_x == acc[m_len-1]) ? P_RUN : P_ERR;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("we",    64'(bus.PROG_LOADER_Mem_We_out),      64'(e_we));
    chk("addr",  64'(bus.PROG_LOADER_Mem_Addr_OutBUS), 64'(e_addr));
    chk("data",  64'(bus.PROG_LOADER_Mem_Data_OutBUS), 64'(e_data));
    chk("ready", 64'(bus.PROG_LOADER_Byte_Ready_out),  64'(ph == P_LOAD));
    chk("done",  64'(bus.PROG_LOADER_Done_out),        64'(ph == P_RUN));
    chk("error", 64'(bus.PROG_LOADER_Error_out),       64'(ph == P_ERR));
    chk("crst",  64'(bus.PROG_LOADER_Core_Reset_out),  64'(ph == P_RUN));
  end

  function automatic bq_t mk_image(input wq_t w, input bit bad);
    bq_t s;
    byte unsigned x;
    logic [31:0] n;
    logic [31:0] v;
    n = 32'(w.size());
    for (int k = 0; k < 4; k++) s.push_back(n[8*k +: 8]);
    for (int i = 0; i < w.size(); i++) begin
      v = w[i];
      for (int k = 0; k < 4; k++) s.push_back(v[8*k +: 8]);
    end
    x = 0;
    foreach (s[i]) x ^= s[i];
    s.push_back(bad ? (x ^ 8'h01) : x);
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.PROG_LOADER_Byte_Valid_in = 1'b0;
      bus.PROG_LOADER_Start_in      = 1'b0;
    end
  endtask

  task automatic send_byte(input byte unsigned b, input int max_gap, input bit start_in_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) begin
      @(negedge clk);
      bus.PROG_LOADER_Byte_Valid_in = 1'b0;
      bus.PROG_LOADER_Start_in      = start_in_gap && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.PROG_LOADER_Start_in      = 1'b0;
    bus.PROG_LOADER_Byte_Valid_in = 1'b1;
    bus.PROG_LOADER_Byte_InBUS    = b;
  endtask

  task automatic send_stream(input bq_t s, input int max_gap, input bit start_in_gap);
    foreach (s[i]) send_byte(s[i], max_gap, start_in_gap);
    idle(3);
  endtask

  task automatic restart();
    @(negedge clk);
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    bus.PROG_LOADER_Start_in      = 1'b1;
    @(negedge clk);
    bus.PROG_LOADER_Start_in      = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic dn, input logic er, input logic cr);
    chk({tag, "_ready"}, 64'(bus.PROG_LOADER_Byte_Ready_out), 64'(rdy));
    chk({tag, "_done"},  64'(bus.PROG_LOADER_Done_out),       64'(dn));
    chk({tag, "_error"}, 64'(bus.PROG_LOADER_Error_out),      64'(er));
    chk({tag, "_crst"},  64'(bus.PROG_LOADER_Core_Reset_out), 64'(cr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_status(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, "_we"},   64'(bus.PROG_LOADER_Mem_We_out),      64'd0);
    chk({tag, "_addr"}, 64'(bus.PROG_LOADER_Mem_Addr_OutBUS), 64'd0);
    chk({tag, "_data"}, 64'(bus.PROG_LOADER_Mem_Data_OutBUS), 64'd0);
  endtask

  initial begin
    bq_t  nom, bad, hdr, one;
    wq_t  w;
    int   base;
    bus.PROG_LOADER_Start_in      = 1'b0;
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    bus.PROG_LOADER_Byte_InBUS    = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    #2 rst_n = 1'b1;

    // Nominal image; model checksum pinned to the hand-computed byte
    nom = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h0F, 8'hF0, 8'hFF, 8'h82};
    w = '{32'h00000013, 32'hFFF00F93};
    one = mk_image(w, 1'b0);
    chk("model_csum", 64'(one[12]), 64'h82);
    send_stream(nom, 0, 1'b0);
    chk_status("nom", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("nom_mem0", 64'(tb_mem[0]), 64'h00000013);
    chk("nom_mem1", 64'(tb_mem[1]), 64'hFFF00F93);
    chk("nom_wecnt", 64'(we_cnt), 64'd2);

    // Reload a 1-word image; core reset drops right after Start
    restart();
    chk_status("start", 1'b1, 1'b0, 1'b0, 1'b0);
    one = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    send_stream(one, 0, 1'b0);
    chk_status("one", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("one_mem0", 64'(tb_mem[0]), 64'hDEADBEEF);
    chk("one_mem1", 64'(tb_mem[1]), 64'hFFF00F93);
    chk("one_wecnt", 64'(we_cnt), 64'd3);

    // Bad checksum
    restart();
    bad = nom;
    bad[12] = 8'h83;
    send_stream(bad, 0, 1'b0);
    chk_status("badcs", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("badcs_wecnt", 64'(we_cnt), 64'd5);
    restart();
    chk_status("badcs_start", 1'b1, 1'b0, 1'b0, 1'b0);

    // Out-of-range headers: 0, 0x401, 0x10001
    hdr = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(hdr, 0, 1'b0);
    chk_status("hdr0", 1'b0, 1'b0, 1'b1, 1'b0);
    restart();
    hdr = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_stream(hdr, 0, 1'b0);
    chk_status("hdr401", 1'b0, 1'b0, 1'b1, 1'b0);
    restart();
    hdr = '{8'h01, 8'h00, 8'h01, 8'h00};
    send_stream(hdr, 0, 1'b0);
    chk_status("hdr10001", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hdr_wecnt", 64'(we_cnt), 64'd5);

    // Nominal stream with bubbles; Start pulses in gaps must be ignored
    restart();
    send_stream(nom, 5, 1'b1);
    chk_status("bub", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bub_mem0", 64'(tb_mem[0]), 64'h00000013);
    chk("bub_mem1", 64'(tb_mem[1]), 64'hFFF00F93);
    chk("bub_wecnt", 64'(we_cnt), 64'd7);

    // Full-capacity image (N = 2**ADDR_WIDTH)
    restart();
    w.delete();
    for (int i = 0; i < (1 << AW); i++) w.push_back($urandom);
    send_stream(mk_image(w, 1'b0), 0, 1'b0);
    chk_status("full", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("full_last", 64'(tb_mem[(1<<AW)-1]), 64'(w[(1<<AW)-1]));

    // Random images, some with corrupted checksum
    for (int it = 0; it < 8; it++) begin
      restart();
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) w.push_back($urandom);
      send_stream(mk_image(w, $urandom_range(0, 2) == 0), 3, 1'b1);
    end

    // Reset mid-load after 6 data bytes, then a clean reload
    restart();
    base = we_cnt;
    for (int i = 0; i < 10; i++) send_byte(nom[i], 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_stream(nom, 0, 1'b0);
    chk_status("rel", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rel_mem0", 64'(tb_mem[0]), 64'h00000013);
    chk("rel_mem1", 64'(tb_mem[1]), 64'hFFF00F93);
    chk("rel_wecnt", 64'(we_cnt - base), 64'd3);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
